// File: rtl/dmem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_pkg                                                        |
// | Shared types, constants and the byte-merge helper for the       |
// | data-memory arbiter.                                            |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Native word geometry of the data RAM this block was built around
  localparam int PKG_DW = 32;
  localparam int PKG_BW = PKG_DW / 8;

  localparam logic [PKG_BW-1:0] BE_FULL = {PKG_BW{1'b1}};
  localparam logic [PKG_BW-1:0] BE_NONE = {PKG_BW{1'b0}};

  // Per byte lane: take the new lane where enabled, otherwise keep the old one
  function automatic logic [PKG_DW-1:0] merge_bytes(
    input logic [PKG_DW-1:0] old_word,
    input logic [PKG_DW-1:0] new_word,
    input logic [PKG_BW-1:0] be
  );
    logic [PKG_DW-1:0] result;
    result = old_word;
    for (int i = 0; i < PKG_BW; i++) begin
      if (be[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_arb2                                                         |
// | Two-way picker: round-robin on a tie when RR_EN=1, otherwise    |
// | port A always wins a tie.                                       |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module rr_arb2
  import dmem_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic rr_last;

  // Grant decision; nothing is granted while the arbiter is disabled
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        if ((RR_EN != 0) && (rr_last == PORT_A)) gnt_b = 1'b1;
        else                                     gnt_a = 1'b1;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // Remember the last winner; reset to B so that A wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= PORT_B;
    end else if (gnt_a) begin
      rr_last <= PORT_A;
    end else if (gnt_b) begin
      rr_last <= PORT_B;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_arbiter                                                    |
// | Shares a single-port data RAM between CPU (A) and loader (B).   |
// | Sub-word stores are done by read-modify-write; overflowing A    |
// | stores are suppressed here.                                     |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int RR_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [DW/8-1:0] a_be,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wd,
  input  logic            a_ov,
  output logic            a_gnt,
  output logic            a_ack,
  output logic [DW-1:0]   a_rdata,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [DW/8-1:0] b_be,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_wd,
  output logic            b_gnt,
  output logic            b_ack,
  output logic [DW-1:0]   b_rdata,
  output logic            ram_we,
  output logic [31:0]     ram_addr,
  output logic [DW-1:0]   ram_wd,
  output logic            ram_ov,
  input  logic [DW-1:0]   ram_rd
);

  localparam int BW = DW / 8;

  state_t          state;
  logic [DW-1:0]   merge_old;
  logic [DW-1:0]   merge_wd;
  logic [BW-1:0]   merge_be;
  logic [AW-1:0]   merge_addr;
  logic            merge_port;
  logic [DW-1:0]   merged;

  logic            granted;
  logic            sel_we;
  logic [BW-1:0]   sel_be;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wd;
  logic            sel_ov;
  logic            full_wr;
  logic            partial_wr;

  rr_arb2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .req_a (a_req),
    .req_b (b_req),
    .gnt_a (a_gnt),
    .gnt_b (b_gnt)
  );

  // Suppression of overflowing stores happens here, never in the RAM
  assign ram_ov = 1'b0;

  // Merge is built from registered old data so ram_rd never reaches ram_wd combinationally
  if (DW == PKG_DW) begin : g_merge_pkg
    assign merged = merge_bytes(merge_old, merge_wd, merge_be);
  end else begin : g_merge_lane
    for (genvar i = 0; i < BW; i++) begin : g_lane
      assign merged[8*i +: 8] = merge_be[i] ? merge_wd[8*i +: 8] : merge_old[8*i +: 8];
    end
  end

  // Mux the winning port's request fields and classify the write
  always_comb begin
    granted    = a_gnt | b_gnt;
    sel_we     = b_gnt ? b_we   : a_we;
    sel_be     = b_gnt ? b_be   : a_be;
    sel_addr   = b_gnt ? b_addr : a_addr;
    sel_wd     = b_gnt ? b_wd   : a_wd;
    sel_ov     = a_gnt & a_ov;
    full_wr    = granted & sel_we & ~sel_ov & (&sel_be);
    partial_wr = granted & sel_we & ~sel_ov & (|sel_be) & ~(&sel_be);
  end

  // RAM strobe/address/data: merge write in MERGE, winner's access in IDLE
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = 32'd0;
    ram_wd   = '0;
    if (state == MERGE) begin
      ram_we   = 1'b1;
      ram_addr = {{(32-AW){1'b0}}, merge_addr};
      ram_wd   = merged;
    end else if (granted) begin
      ram_we   = full_wr;
      ram_addr = {{(32-AW){1'b0}}, sel_addr};
      ram_wd   = sel_we ? sel_wd : '0;
    end
  end

  // Access FSM with merge buffer and registered ack/rdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      merge_old  <= '0;
      merge_wd   <= '0;
      merge_be   <= '0;
      merge_addr <= '0;
      merge_port <= PORT_A;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (granted) begin
            if (partial_wr) begin
              merge_old  <= ram_rd;
              merge_wd   <= sel_wd;
              merge_be   <= sel_be;
              merge_addr <= sel_addr;
              merge_port <= b_gnt ? PORT_B : PORT_A;
              state      <= MERGE;
            end else begin
              a_ack <= a_gnt;
              b_ack <= b_gnt;
              if (a_gnt && !a_we) a_rdata <= ram_rd;
              if (b_gnt && !b_we) b_rdata <= ram_rd;
            end
          end
        end
        MERGE: begin
          a_ack <= (merge_port == PORT_A);
          b_ack <= (merge_port == PORT_B);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
